// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, baud defaults, frame sizes.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam int unsigned BaudScaleDefault = 10416;
  localparam int unsigned FrameBits8N1     = 10;
  localparam int unsigned FrameBits8E1     = 11;
  localparam int unsigned BaudCntW         = 16;

  // Terminal count of the baud counter for a given cycles-per-bit scale.
  function automatic logic [BaudCntW-1:0] baud_last(input int unsigned scale);
    return BaudCntW'(scale - 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo NReq.
module uart_rr_picker #(
  parameter int unsigned NReq = 4
) (
  input  logic [NReq-1:0]         req_i,
  input  logic [$clog2(NReq)-1:0] ptr_i,
  output logic                    any_o,
  output logic [$clog2(NReq)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(NReq);

  logic [IdxW-1:0] cand;
  int unsigned     sum;

  // Scan from the farthest candidate down so the nearest set bit wins.
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    cand  = '0;
    sum   = 0;
    for (int k = NReq - 1; k >= 0; k--) begin
      sum = int'(ptr_i) + k;
      if (sum >= NReq) sum = sum - NReq;
      cand = IdxW'(sum);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between N_REQ byte producers.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned _BAUD_SCALE = BaudScaleDefault,
  parameter int unsigned N_REQ       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       data,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     RsTx
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [BaudCntW-1:0] CntLast = baud_last(_BAUD_SCALE);

  state_e              state_q, state_d;
  logic [BaudCntW-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                tx_q, tx_d;
`ifdef UART_TX_ARB_PARITY_EN
  logic                par_q, par_d;
`endif

  logic            pick_any;
  logic [IdxW-1:0] pick_idx;
  logic [7:0]      lane [N_REQ];
  logic            bit_end;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = data[8*i +: 8];
  end

  uart_rr_picker #(
    .NReq(N_REQ)
  ) u_picker (
    .req_i(req),
    .ptr_i(ptr_q),
    .any_o(pick_any),
    .idx_o(pick_idx)
  );

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + BaudCntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    tx_d    = tx_q;
`ifdef UART_TX_ARB_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        tx_d   = 1'b1;
        if (pick_any) begin
          state_d         = StStart;
          owner_d         = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          shift_d         = lane[pick_idx];
          ptr_d           = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
          busy_d          = 1'b1;
          tx_d            = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
          par_d           = ^lane[pick_idx];
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            // Shift right so the next data bit is always at shift_q[1].
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign RsTx  = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model plus directed/random stimulus.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int B = 4;
  localparam int N = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FB = FrameBits8E1;
`else
  localparam int FB = FrameBits8N1;
`endif
  localparam int FLEN = B * FB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         RsTx;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    ._BAUD_SCALE(B),
    .N_REQ(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .RsTx(RsTx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is a bit vector replayed for B cycles per bit.
  logic         m_active = 1'b0;
  int           m_pos    = 0;
  logic [N-1:0] m_gnt    = '0;
  int           m_owner  = 0;
  int           m_ptr    = 0;
  logic [10:0]  m_frame  = '1;
  int           mp;
  logic [7:0]   mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_gnt    <= '0;
      m_owner  <= 0;
      m_ptr    <= 0;
    end else begin
      m_gnt <= '0;
      if (m_active) begin
        if (m_pos == FLEN - 1) begin
          m_active <= 1'b0;
          m_pos    <= 0;
        end else begin
          m_pos <= m_pos + 1;
        end
      end else if (req != '0) begin
        mp = -1;
        for (int k = 0; k < N; k++)
          if (mp < 0 && req[(m_ptr + k) % N]) mp = (m_ptr + k) % N;
        mb = data[8*mp +: 8];
`ifdef UART_TX_ARB_PARITY_EN
        m_frame <= {1'b1, ^mb, mb, 1'b0};
`else
        m_frame <= {1'b1, 1'b1, mb, 1'b0};
`endif
        m_active  <= 1'b1;
        m_pos     <= 0;
        m_gnt     <= N'(1) << mp;
        m_owner   <= mp;
        m_ptr     <= (mp + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_active);
    chk("tx", RsTx, m_active ? m_frame[m_pos / B] : 1'b1);
    chk("gnt", gnt, m_gnt);
    if (m_active) chk("owner", owner, m_owner);
  end

  int gq_lane[$];
  int gq_cyc[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_grant();
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        gq_lane.push_back(i);
        gq_cyc.push_back(cyc);
      end
    req = req & ~gnt;
  endtask

  task automatic run_until_grants(input int ngr, input int budget);
    int start = gq_lane.size();
    int n = 0;
    while (gq_lane.size() - start < ngr && n < budget) begin
      @(negedge clk);
      n++;
      if (gnt != '0) push_grant();
    end
    chk("grant_timeout", gq_lane.size() - start, ngr);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * FLEN) begin
      @(negedge clk);
      n++;
      if (gnt != '0) push_grant();
    end
    chk("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One isolated frame from `ln`: returns the sampled bit vector and busy-cycle count.
  task automatic frame_capture(input int ln, input logic [7:0] b, output logic [10:0] bits,
                               output int bcnt);
    bits = '0;
    bcnt = 0;
    data[8*ln +: 8] = b;
    req[ln] = 1'b1;
    for (int k = 0; k < FLEN + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("cap_gnt", gnt, N'(1) << ln);
        req[ln] = 1'b0;
      end
      if (busy) bcnt++;
      if (k % B == 2 && k < FLEN) bits[k / B] = RsTx;
    end
  endtask

  logic [10:0] bits;
  int          bcnt;
  int          g1cnt;
  int          bseen;
  int          base;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tx", RsTx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single request, lane 0 = 0x55.
    frame_capture(0, 8'h55, bits, bcnt);
`ifdef UART_TX_ARB_PARITY_EN
    chk("single_bits", bits, 11'b10010101010);
`else
    chk("single_bits", bits, 11'b01010101010);
`endif
    chk("single_busy", bcnt, FLEN);

    // Contention from reset: all four lanes.
    do_reset();
    gq_lane.delete();
    gq_cyc.delete();
    data = 32'hA3A2A1A0;
    req  = 4'b1111;
    run_until_grants(4, 5 * (FLEN + 1));
    if (gq_lane.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("cont_order", gq_lane[i], i);
      for (int i = 1; i < 4; i++) chk("cont_gap", gq_cyc[i] - gq_cyc[i-1], FLEN + 1);
    end
    wait_idle();

    // Fairness wrap: lane 2 granted (ptr->3), then lanes 0 and 2 pending.
    gq_lane.delete();
    gq_cyc.delete();
    req = 4'b0100;
    run_until_grants(1, 10);
    req = 4'b0101;
    run_until_grants(2, 3 * (FLEN + 1));
    if (gq_lane.size() == 3) begin
      chk("wrap_first", gq_lane[0], 2);
      chk("wrap_second", gq_lane[1], 0);
      chk("wrap_third", gq_lane[2], 2);
    end
    wait_idle();

    // Mid-frame reset at cycle 17; requests stay high across reset.
    data = 32'h44332211;
    req  = 4'b0110;
    @(negedge clk);
    chk("mr_gnt", gnt, 4'b0010);
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_tx_async", RsTx, 1'b1);
    chk("mr_busy_async", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_regnt", gnt, 4'b0010);
    chk("mr_owner", owner, 2'd1);
    chk("mr_start", RsTx, 1'b0);
    req = 4'b0000;
    wait_idle();

    // Withdrawal: lane 1 asserts mid-frame and drops before IDLE.
    req = 4'b0001;
    run_until_grants(1, 10);
    repeat (10) @(negedge clk);
    req[1] = 1'b1;
    g1cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt[1]) g1cnt++;
    end
    req[1] = 1'b0;
    wait_idle();
    bseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt[1]) g1cnt++;
      if (busy) bseen++;
    end
    chk("wd_gnt1", g1cnt, 0);
    chk("wd_busy", bseen, 0);

`ifdef UART_TX_ARB_PARITY_EN
    frame_capture(3, 8'h07, bits, bcnt);
    chk("par07_bits", bits, 11'b11000001110);
    chk("par07_len", bcnt, 44);
    frame_capture(3, 8'h03, bits, bcnt);
    chk("par03_bits", bits, 11'b10000000110);
`endif

    // Random requester traffic obeying the handshake rules.
    base = gq_lane.size();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else data[8*i +: 8] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(7, 0) == 0) begin
            req[i] = 1'b1;
            data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(63, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
